// File: rtl/alu_pkg.sv
// Shared encodings and small decode helpers for the iterative ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_OR    = 3'd0;
  localparam logic [OP_W-1:0] OP_AND   = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd3;
  localparam logic [OP_W-1:0] OP_MUL   = 3'd4;
  localparam logic [OP_W-1:0] OP_MULHU = 3'd5;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd6;
  localparam logic [OP_W-1:0] OP_REMU  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // MULHU and REMU take the upper accumulator half; MUL and DIVU the lower.
  function automatic logic is_hi_op(input logic [OP_W-1:0] op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-clock unsigned shift-add multiplier and restoring divider.
// res_*_c present the post-iteration value so the caller can register it on the done edge.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_c,
  output logic [WIDTH-1:0] res_lo_c,
  output logic [WIDTH-1:0] res_hi_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opb_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q;

  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  // Multiply: lo holds the multiplier and shifts right into the product.
  // Divide: lo holds the dividend, shifts left and collects quotient bits.
  always_comb begin
    sum   = {1'b0, hi_q} + {1'b0, opb_q};
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opb_q};
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (div_q) begin
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_d = {1'b0, hi_q[WIDTH-1:1]};
      lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= is_div ? a : b;
      opb_q <= is_div ? b : a;
      cnt_q <= CW'(WIDTH - 1);
      div_q <= is_div;
    end else if (step) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_c   = step && (cnt_q == '0);
  assign res_lo_c = lo_d;
  assign res_hi_c = hi_d;

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle logic/add/sub, iterative mul/mulhu/divu/remu.
// Registered result and zero flag; ready_o is combinational on state and ready_i.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  state_e           state_q;
  state_e           state_d;
  logic [OP_W-1:0]  op_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  logic             accept;
  logic             iter_start;
  logic             iter_step;
  logic             iter_done_c;
  logic [WIDTH-1:0] iter_lo_c;
  logic [WIDTH-1:0] iter_hi_c;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH-1:0] alu_res;

  assign ready_o    = (state_q == S_IDLE) || ((state_q == S_DONE) && ready_i);
  assign accept     = valid_i && ready_o;
  assign iter_start = accept && is_iter_op(op_i);
  assign iter_step  = (state_q == S_BUSY);
  assign iter_res   = is_hi_op(op_q) ? iter_hi_c : iter_lo_c;

  alu_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .start    (iter_start),
    .step     (iter_step),
    .is_div   (is_div_op(op_i)),
    .a        (data1_i),
    .b        (data2_i),
    .done_c   (iter_done_c),
    .res_lo_c (iter_lo_c),
    .res_hi_c (iter_hi_c)
  );

  always_comb begin
    alu_res = '0;
    case (op_i)
      OP_OR:   alu_res = data1_i | data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  // Next state; DONE with ready_i doubles as an accept slot for back-to-back ops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = is_iter_op(op_i) ? S_BUSY : S_DONE;
        end else if ((state_q == S_DONE) && ready_i) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (iter_done_c) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_OR;
      data_q  <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == S_DONE);
      if (accept) begin
        op_q <= op_i;
      end
      if (accept && !is_iter_op(op_i)) begin
        data_q <= alu_res;
        zero_q <= (alu_res == '0);
      end else if (iter_done_c) begin
        data_q <= iter_res;
        zero_q <= (iter_res == '0);
      end
    end
  end

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter: table of ops plus reset, backpressure and streaming sequences.
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [2:0]   op_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         zero_o;

  int checks;
  int failures;

  alu_iter #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .data1_i (data1_i),
    .data2_i (data2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .zero_o  (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          edges;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready_o !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready_o !== 1'b1) begin
      failures++;
      checks++;
      $display("FAIL %s_ready_timeout: got %b expected 1", name, ready_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{"add_wrap",   3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0};
    vecs[1]  = '{"sub_neg",    3'd3, 32'd3,         32'd5,         32'hFFFF_FFFE, 0};
    vecs[2]  = '{"or",         3'd0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 0};
    vecs[3]  = '{"and",        3'd1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0};
    vecs[4]  = '{"mul_max",    3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
    vecs[5]  = '{"mulhu_max",  3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    vecs[6]  = '{"divu",       3'd6, 32'd100,       32'd7,         32'd14,        32};
    vecs[7]  = '{"remu",       3'd7, 32'd100,       32'd7,         32'd2,         32};
    vecs[8]  = '{"divu_zero",  3'd6, 32'd5,         32'd0,         32'hFFFF_FFFF, 32};
    vecs[9]  = '{"remu_zero",  3'd7, 32'd5,         32'd0,         32'd5,         32};
    vecs[10] = '{"mul_zero",   3'd4, 32'd7,         32'd0,         32'd0,         32};
    vecs[11] = '{"mul_small",  3'd4, 32'd12345,     32'd1000,      32'd12345000,  32};
    vecs[12] = '{"mulhu_pow2", 3'd5, 32'h8000_0000, 32'd4,         32'd2,         32};
    vecs[13] = '{"divu_big",   3'd6, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32};
    vecs[14] = '{"remu_big",   3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32};

    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 3'd0;
    data1_i = '0;
    data2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b1;

    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data",  data_o,       32'd0);
    check("rst_zero",  32'(zero_o),  32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);

    for (int i = 0; i < 15; i++) begin
      int lat;
      int busy_bad;
      wait_ready(vecs[i].name);
      valid_i = 1'b1;
      op_i    = vecs[i].op;
      data1_i = vecs[i].a;
      data2_i = vecs[i].b;
      @(posedge clk); #1;
      valid_i  = 1'b0;
      data1_i  = 32'hDEAD_BEEF;
      data2_i  = 32'h1234_5678;
      lat      = 0;
      busy_bad = 0;
      while (valid_o !== 1'b1 && lat < 100) begin
        if (ready_o !== 1'b0) busy_bad++;
        @(posedge clk); #1;
        lat++;
      end
      check({vecs[i].name, "_lat"},  32'(lat),    32'(vecs[i].edges));
      check({vecs[i].name, "_data"}, data_o,      vecs[i].exp);
      check({vecs[i].name, "_zero"}, 32'(zero_o), 32'(vecs[i].exp == 32'd0));
      if (vecs[i].edges > 0) check({vecs[i].name, "_busy_ready"}, 32'(busy_bad), 32'd0);
      @(posedge clk); #1;
    end

    // Backpressure: ADD 2+2 held for 5 cycles, then same-edge handoff to SUB 9-4.
    begin
      int hold_bad = 0;
      ready_i = 1'b0;
      wait_ready("bp");
      valid_i = 1'b1;
      op_i    = 3'd2;
      data1_i = 32'd2;
      data2_i = 32'd2;
      @(posedge clk); #1;
      valid_i = 1'b0;
      check("bp_first_valid", 32'(valid_o), 32'd1);
      check("bp_first_data",  data_o,       32'd4);
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        if (valid_o !== 1'b1 || data_o !== 32'd4 || ready_o !== 1'b0) hold_bad++;
      end
      check("bp_hold", 32'(hold_bad), 32'd0);
      ready_i = 1'b1;
      valid_i = 1'b1;
      op_i    = 3'd3;
      data1_i = 32'd9;
      data2_i = 32'd4;
      #1;
      check("bp_ready_comb", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      valid_i = 1'b0;
      check("bp_handoff_valid", 32'(valid_o), 32'd1);
      check("bp_handoff_data",  data_o,       32'd5);
      @(posedge clk); #1;
      check("bp_drain_valid", 32'(valid_o), 32'd0);
    end

    // Streaming: 8 back-to-back ADDs, one result per cycle.
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_s;
      exp_s   = 32'd100 + 32'(3 * i);
      valid_i = 1'b1;
      op_i    = 3'd2;
      data1_i = 32'd100;
      data2_i = 32'(3 * i);
      check($sformatf("stream%0d_ready", i), 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      check($sformatf("stream%0d_valid", i), 32'(valid_o), 32'd1);
      check($sformatf("stream%0d_data", i),  data_o,       exp_s);
    end
    valid_i = 1'b0;

    // Reset mid-DIVU: no result may surface afterwards.
    begin
      int late_bad = 0;
      wait_ready("rstmid");
      valid_i = 1'b1;
      op_i    = 3'd6;
      data1_i = 32'd100;
      data2_i = 32'd7;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (10) begin
        @(posedge clk); #1;
      end
      check("rstmid_busy_ready", 32'(ready_o), 32'd0);
      rst_i = 1'b0;
      @(posedge clk); #1;
      rst_i = 1'b1;
      check("rstmid_valid", 32'(valid_o), 32'd0);
      check("rstmid_data",  data_o,       32'd0);
      check("rstmid_zero",  32'(zero_o),  32'd1);
      check("rstmid_ready", 32'(ready_o), 32'd1);
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 32'd0) late_bad++;
      end
      check("rstmid_no_result", 32'(late_bad), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
